// File: rtl/iob_cache_mem_model_pkg.sv
// rtl/iob_cache_mem_model_pkg.sv - shared types and constants for the cache back-end memory model
//
// Holds the FSM state encoding, the LFSR tap mask and its step function,
// and the wait counter width used by iob_cache_mem_model.

package iob_cache_mem_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Wait counter must hold up to 15 - 1 + 3 = 17.
    localparam int CNT_W = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/iob_sp_ram.sv
// rtl/iob_sp_ram.sv - single-port RAM with per-byte write enables and registered read
//
// Ports:
//   clk  : clock
//   en   : enable for both read and write
//   we   : per-byte write enables
//   addr : word address
//   din  : write data
//   dout : registered read data (old contents on a same-cycle write)

module iob_sp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                end
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/iob_cache_mem_model.sv
// rtl/iob_cache_mem_model.sv - latency-configurable native-interface back-end memory for cache simulation
//
// Answers one mem_* request at a time after RD_LAT/WR_LAT cycles plus optional
// pseudo-random stalls, counts completed reads/writes and flags requests that
// change or drop while waiting.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb : request (wstrb == 0 means read)
//   mem_rdata, mem_ready  : response data and one-cycle completion pulse
//   rd_cnt, wr_cnt        : completed read / write counts (wrap at 2**32)
//   proto_err             : sticky protocol-violation flag

module iob_cache_mem_model
    import iob_cache_mem_model_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 16,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt,
    output logic                  proto_err
);

    localparam int NBYTES      = DATA_W / 8;
    localparam int OFF_W       = $clog2(NBYTES);
    localparam int WORD_ADDR_W = ADDR_W - OFF_W;

    localparam logic [CNT_W-1:0] RD_L = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_L = CNT_W'(WR_LAT);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_load, extra;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [NBYTES-1:0]      wstrb_q;
    logic [15:0]            lfsr;
    logic [DATA_W-1:0]      rdata_hold;
    logic [DATA_W-1:0]      ram_dout;
    logic [WORD_ADDR_W-1:0] ram_addr;
    logic [NBYTES-1:0]      ram_we;
    logic                   is_wr_q;
    logic                   req_changed;

    assign is_wr_q  = |wstrb_q;
    assign extra    = (STALL_EN != 0) ? {{(CNT_W-2){1'b0}}, lfsr[1:0]} : '0;
    assign cnt_load = ((|mem_wstrb) ? WR_L : RD_L) - CNT_W'(1) + extra;

    assign req_changed = !mem_valid || (mem_addr != addr_q) ||
                         (mem_wstrb != wstrb_q) || (mem_wdata != wdata_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    cnt_nxt   = cnt_load;
                    state_nxt = (cnt_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The RAM read is registered: while IDLE it follows the live address so a
    // zero-wait request has data ready in RESP; afterwards it follows the
    // latched address so a changing bus cannot corrupt the transaction.
    assign ram_addr = (state == ST_IDLE) ? mem_addr[ADDR_W-1:OFF_W] : addr_q[ADDR_W-1:OFF_W];
    // Gated by reset so a transaction in RESP when reset hits is dropped.
    assign ram_we   = (state == ST_RESP && !reset) ? wstrb_q : '0;

    assign mem_ready = (state == ST_RESP);
    assign mem_rdata = (state == ST_RESP && !is_wr_q) ? ram_dout : rdata_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            lfsr       <= LFSR_SEED;
            rdata_hold <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            proto_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= lfsr_next(lfsr);
            if (state == ST_IDLE && mem_valid) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (state == ST_WAIT && req_changed) begin
                proto_err <= 1'b1;
            end
            if (state == ST_RESP) begin
                if (is_wr_q) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt     <= rd_cnt + 32'd1;
                    rdata_hold <= ram_dout;
                end
            end
        end
    end

    iob_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (WORD_ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (1'b1),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_iob_cache_mem_model.sv
// tb/tb_iob_cache_mem_model.sv - directed and scoreboard bench for iob_cache_mem_model

module tb_iob_cache_mem_model;

    logic        clk = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        valid  [4];
    logic        rst    [4];
    logic        ready  [4];
    logic        perr   [4];
    logic [31:0] rdata  [4];
    logic [31:0] rd_cnt [4];
    logic [31:0] wr_cnt [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 0: legacy 1/1   1: RD4/WR2   2: RD4/WR4   3: stalls, RD2/WR3
    iob_cache_mem_model #(.RD_LAT(1), .WR_LAT(1)) dut_a (
        .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
        .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]), .proto_err(perr[0]));
    iob_cache_mem_model #(.RD_LAT(4), .WR_LAT(2)) dut_b (
        .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
        .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]), .proto_err(perr[1]));
    iob_cache_mem_model #(.RD_LAT(4), .WR_LAT(4)) dut_c (
        .clk(clk), .reset(rst[2]), .mem_valid(valid[2]), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[2]), .mem_ready(ready[2]),
        .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]), .proto_err(perr[2]));
    iob_cache_mem_model #(.RD_LAT(2), .WR_LAT(3), .STALL_EN(1), .LFSR_SEED(16'hACE1)) dut_s (
        .clk(clk), .reset(rst[3]), .mem_valid(valid[3]), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[3]), .mem_ready(ready[3]),
        .rd_cnt(rd_cnt[3]), .wr_cnt(wr_cnt[3]), .proto_err(perr[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on DUT i. lat = cycles from the valid cycle to ready.
    // glitch_at > 0 moves addr to glitch_addr that many cycles in;
    // rst_at > 0 pulses reset that many cycles in and abandons the request (lat = -1).
    task automatic access(input int i, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int glitch_at, input logic [15:0] glitch_addr,
                          input int rst_at, output logic [31:0] rd, output int lat);
        bit done = 0;
        @(negedge clk);
        valid[i] = 1'b1;
        addr     = a;
        wdata    = d;
        wstrb    = s;
        lat      = 0;
        rd       = '0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (rst_at != 0 && lat == rst_at) begin
                rst[i] = 1'b1;
                @(negedge clk);
                check("ready_after_reset", 32'(ready[i]), 32'd0);
                rst[i]   = 1'b0;
                valid[i] = 1'b0;
                lat      = -1;
                return;
            end
            if (glitch_at != 0 && lat == glitch_at) addr = glitch_addr;
            if (ready[i]) begin
                rd   = rdata[i];
                done = 1;
            end else if (lat >= 60) begin
                check("ready_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        valid[i] = 1'b0;
        @(negedge clk);
        check("ready_one_pulse", 32'(ready[i]), 32'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] rd;
    int          lat;
    logic [31:0] model [16];
    int          n_wr, n_rd, bad_lat;
    logic [3:0]  seen_rd, seen_wr;

    initial begin
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            rst[i]   = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", 32'(ready[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_rd_cnt", rd_cnt[0], 32'd0);
        check("rst_wr_cnt", wr_cnt[0], 32'd0);
        check("rst_perr", 32'(perr[0]), 32'd0);

        // Legacy 1-cycle behaviour
        access(0, 16'h0040, 32'h11223344, 4'hF, 0, 0, 0, rd, lat);
        check("a_wr_lat", lat, 32'd1);
        access(0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, rd, lat);
        check("a_rd_lat", lat, 32'd1);
        check("a_rd_data", rd, 32'h11223344);
        check("a_wr_cnt", wr_cnt[0], 32'd1);
        check("a_rd_cnt", rd_cnt[0], 32'd1);

        // Byte strobes
        access(0, 16'h0040, 32'hAABBCCDD, 4'b0100, 0, 0, 0, rd, lat);
        check("a_rdata_hold_on_wr", rdata[0], 32'h11223344);
        access(0, 16'h0042, 32'h0, 4'h0, 0, 0, 0, rd, lat);
        check("a_strobe_data", rd, 32'h11BB3344);
        access(0, 16'h0040, 32'hFFFFFFFF, 4'h0, 0, 0, 0, rd, lat);
        check("a_zero_strb_data", rd, 32'h11BB3344);
        check("a_zero_strb_wr_cnt", wr_cnt[0], 32'd2);
        check("a_zero_strb_rd_cnt", rd_cnt[0], 32'd3);

        // Long latencies
        access(1, 16'h0040, 32'h55667788, 4'hF, 0, 0, 0, rd, lat);
        check("b_wr_lat", lat, 32'd2);
        access(1, 16'h0040, 32'h0, 4'h0, 0, 0, 0, rd, lat);
        check("b_rd_lat", lat, 32'd4);
        check("b_rd_data", rd, 32'h55667788);

        // Protocol checker
        access(2, 16'h0040, 32'hCAFE0001, 4'hF, 0, 0, 0, rd, lat);
        access(2, 16'h0044, 32'h0BADBEEF, 4'hF, 0, 0, 0, rd, lat);
        access(2, 16'h0080, 32'h12345678, 4'hF, 0, 0, 0, rd, lat);
        check("c_perr_clean", 32'(perr[2]), 32'd0);
        access(2, 16'h0040, 32'h0, 4'h0, 1, 16'h0044, 0, rd, lat);
        check("c_glitch_data", rd, 32'hCAFE0001);
        check("c_glitch_lat", lat, 32'd4);
        check("c_perr_set", 32'(perr[2]), 32'd1);
        access(2, 16'h0044, 32'h0, 4'h0, 0, 0, 0, rd, lat);
        check("c_clean_data", rd, 32'h0BADBEEF);
        check("c_perr_sticky", 32'(perr[2]), 32'd1);

        // Reset during WAIT of a write
        access(2, 16'h0080, 32'hFFFFFFFF, 4'hF, 0, 0, 2, rd, lat);
        check("c_rst_wr_cnt", wr_cnt[2], 32'd0);
        check("c_rst_rd_cnt", rd_cnt[2], 32'd0);
        check("c_rst_perr", 32'(perr[2]), 32'd0);
        check("c_rst_rdata", rdata[2], 32'd0);
        begin
            int ready_seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (ready[2]) ready_seen++;
            end
            check("c_rst_no_ready", ready_seen, 32'd0);
        end
        access(2, 16'h0080, 32'h0, 4'h0, 0, 0, 0, rd, lat);
        check("c_rst_word_kept", rd, 32'h12345678);
        check("c_rst_wr_cnt_after", wr_cnt[2], 32'd0);

        // Random stalls against a scoreboard
        n_wr = 0; n_rd = 0; bad_lat = 0; seen_rd = '0; seen_wr = '0;
        for (int w = 0; w < 16; w++) begin
            model[w] = 32'hA5000000 | 32'(w);
            access(3, 16'(w*4), model[w], 4'hF, 0, 0, 0, rd, lat);
            n_wr++;
            if (lat < 3 || lat > 6) bad_lat++; else seen_wr[lat-3] = 1'b1;
        end
        for (int k = 0; k < 1000; k++) begin
            int          w = $urandom_range(0, 15);
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                access(3, 16'(w*4), d, s, 0, 0, 0, rd, lat);
                model[w] = merge(model[w], d, s);
                n_wr++;
                if (lat < 3 || lat > 6) bad_lat++; else seen_wr[lat-3] = 1'b1;
            end else begin
                access(3, 16'(w*4 + $urandom_range(0, 3)), d, 4'h0, 0, 0, 0, rd, lat);
                n_rd++;
                check("s_rd_data", rd, model[w]);
                if (lat < 2 || lat > 5) bad_lat++; else seen_rd[lat-2] = 1'b1;
            end
        end
        check("s_bad_latency", bad_lat, 32'd0);
        check("s_seen_rd_lat", 32'(seen_rd), 32'hF);
        check("s_seen_wr_lat", 32'(seen_wr), 32'hF);
        check("s_wr_cnt", wr_cnt[3], 32'(n_wr));
        check("s_rd_cnt", rd_cnt[3], 32'(n_rd));
        check("s_perr", 32'(perr[3]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
